cdc_tx_scheduler: RTL and testbench
===================================

# cdc_tx_scheduler

Clock-domain `clk` scheduler in front of `cdc_unit`. It buffers stereo samples from the DSP path and answers each `cdc_unit` sample request with a tick transfer. It accepts configuration-register writes and sequences them onto the cdc_unit cfg path. Because cdc_unit shares one pulse-synchronised transfer mechanism, the block arbitrates cfg and tick transfers and enforces a guard gap between pulses.

## Interface
- `CDC_GAP_CYCLES`, 4: idle cycles after every transfer pulse, data held stable; legal range 2..15.
- `FIFO_DEPTH`, 4: sample buffer entries (power of two, ≥2).

- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `sample_valid_in` in 1: DSP sample valid.
- `dsp0_in` in 24: left sample.
- `dsp1_in` in 24: right sample.
- `sample_ready_out` out 1: sample accepted when `sample_valid_in && sample_ready_out`.
- `cfg_req_in` in 1: cfg write request, a level held until ack.
- `cfg_data_in` in 32: cfg word, stable while `cfg_req_in` is high.
- `cfg_ack_out` out 1: one-cycle acknowledge.
- `play_in` in 1: play enable.
- `cdc_req_in` in 1: one-cycle request pulse from cdc_unit `req_out`.
- `cdc_dsp0_out` out 24: to cdc_unit `dsp0_in`.
- `cdc_dsp1_out` out 24: to cdc_unit `dsp1_in`.
- `cdc_tick_out` out 1: to cdc_unit `tick_in`.
- `cdc_cfg_out` out 1: to cdc_unit `cfg_in`.
- `cdc_cfg_reg_out` out 32: to cdc_unit `cfg_reg_in`.
- `cdc_play_out` out 1: to cdc_unit `play_in`.
- `underrun_out` out 1: one-cycle pulse when a tick is sent from an empty FIFO.
- `underrun_count_out` out 16: saturating underrun count.

## Operation
- All outputs are registered. Every output resets to 0, and the FIFO, pending flag and FSM are cleared asynchronously.
- `cdc_play_out` is `play_in` delayed by 1 cycle.
- `sample_ready_out` = `play_in && !fifo_full`.
- FIFO entry is `{dsp1, dsp0}` (48 bits). Writes happen on handshake; pops happen on tick issue.
- `req_pending` is set by `cdc_req_in` when `play_in` is high and cleared on tick issue. A second request while pending is absorbed, with no extra tick. When `play_in` is low, requests are ignored.
- FSM states: IDLE, SEND_TICK, SEND_CFG, GAP.
- IDLE, with `play_in` high and (`req_pending` or `cdc_req_in`): go to SEND_TICK. Tick has priority over cfg.
- IDLE, otherwise with `cfg_req_in` high: go to SEND_CFG.
- SEND_TICK (1 cycle):
  - `cdc_tick_out` is 1.
  - The dsp outputs carry the popped entry, or 0 with `underrun_out` pulsing if the FIFO is empty.
- SEND_CFG (1 cycle):
  - `cdc_cfg_out` is 1 and `cfg_ack_out` is 1.
  - `cdc_cfg_reg_out` is loaded from `cfg_data_in`.
- SEND_* always goes to GAP. GAP lasts exactly `CDC_GAP_CYCLES` cycles, then returns to IDLE.
- Data outputs change only on entry to a SEND state and are held otherwise.
- The requester must drop `cfg_req_in` in the cycle after `cfg_ack_out`.
- Falling `play_in`: the FIFO is flushed and `req_pending` is cleared on the next edge. An in-progress SEND/GAP completes normally.
- Simultaneous FIFO write and pop: the count is unchanged. Writes while full are impossible, because ready is low.

## Timing
- `cdc_req_in` sampled high at edge k while in IDLE: `cdc_tick_out` is high in cycle k+1 and the FSM is back in IDLE at cycle k+2+`CDC_GAP_CYCLES`.
- `cfg_req_in` sampled at edge k in IDLE with no tick pending: `cdc_cfg_out` and `cfg_ack_out` are high in cycle k+1.
- Minimum spacing between any two transfer pulses is `CDC_GAP_CYCLES`+1 cycles.
- The underrun decision uses the FIFO count registered at edge k. A sample written at edge k is not visible to it.

## Configuration
- `CDC_SCHED_UNDERRUN_CNT_EN` defined:
  - `underrun_count_out` increments on each `underrun_out` and saturates at 16'hFFFF.
  - It is cleared on reset and on a rising `play_in`.
- Not defined: `underrun_count_out` is tied to 0 and no counter logic exists. `underrun_out` is unaffected.

## Structure
- `audioport_pkg` holds:
  - the `cdc_sched_state_t` enum (IDLE, SEND_TICK, SEND_CFG, GAP);
  - the `CDC_GAP_CYCLES` default constant;
  - the 48-bit `stereo_sample_t` typedef.
- One sub-module, `cdc_sample_fifo`, is a synchronous FIFO with `FIFO_DEPTH` entries. It has write/pop/flush inputs and full/empty/count outputs, and uses the same clock and reset.

## Test plan
- Reset mid-GAP (`rst_n` low for 1 cycle): all outputs 0 immediately, and the FSM restarts in IDLE.
- Play, samples in:
  - Stimulus: `play_in`=1, write samples (0x000111, 0x000222) and (0x000333, 0x000444), then two `cdc_req_in` pulses 10 cycles apart.
  - Response: ticks at req+1 with outputs 0x000111/0x000222, then 0x000333/0x000444, and no underrun.
- Empty FIFO: `cdc_req_in` with the FIFO empty gives a tick with dsp outputs 0 and `underrun_out`=1. With the macro defined, the count goes to 1.
- Simultaneous requests: `cdc_req_in` and `cfg_req_in` (data 0xA5A5_0F0F) in the same cycle, `CDC_GAP_CYCLES`=4.
  - The tick is issued first.
  - `cdc_cfg_out` and `cfg_ack_out` follow exactly 5 cycles later, with `cdc_cfg_reg_out`=0xA5A5_0F0F.
- Play low: with `play_in`=0, a `cdc_req_in` produces no tick and `sample_ready_out` stays 0. Dropping play with 3 samples buffered gives FIFO empty next cycle.
- Back-to-back requests: two `cdc_req_in` pulses during one GAP produce only one extra tick, issued at GAP exit+1.

Source files
------------

// File: rtl/audioport_pkg.sv
// Shared types and defaults for the cdc_unit transmit scheduler and its sample FIFO.
package audioport_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND_TICK,
    SEND_CFG,
    GAP
  } cdc_sched_state_t;

  localparam int DEFAULT_CDC_GAP_CYCLES = 4;
  localparam int DEFAULT_FIFO_DEPTH     = 4;

  // Packs as {dsp1, dsp0}.
  typedef struct packed {
    logic [23:0] dsp1;
    logic [23:0] dsp0;
  } stereo_sample_t;

endpackage

// File: rtl/cdc_sample_fifo.sv
// Synchronous stereo-sample FIFO with flush; head is the oldest entry when not empty.
module cdc_sample_fifo
  import audioport_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     write,
  input  stereo_sample_t           data,
  input  logic                     pop,
  input  logic                     flush,
  output stereo_sample_t           head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  stereo_sample_t mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  // NOTE: the storage array has no reset; pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (write) mem[wr_ptr] <= data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (write) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({write, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/cdc_tx_scheduler.sv
// Arbitrates tick and cfg transfers onto cdc_unit with a guard gap after each pulse.
// Optional saturating underrun counter: define CDC_SCHED_UNDERRUN_CNT_EN.
module cdc_tx_scheduler
  import audioport_pkg::*;
#(
  parameter int CDC_GAP_CYCLES = DEFAULT_CDC_GAP_CYCLES,
  parameter int FIFO_DEPTH     = DEFAULT_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sample_valid_in,
  input  logic [23:0] dsp0_in,
  input  logic [23:0] dsp1_in,
  output logic        sample_ready_out,
  input  logic        cfg_req_in,
  input  logic [31:0] cfg_data_in,
  output logic        cfg_ack_out,
  input  logic        play_in,
  input  logic        cdc_req_in,
  output logic [23:0] cdc_dsp0_out,
  output logic [23:0] cdc_dsp1_out,
  output logic        cdc_tick_out,
  output logic        cdc_cfg_out,
  output logic [31:0] cdc_cfg_reg_out,
  output logic        cdc_play_out,
  output logic        underrun_out,
  output logic [15:0] underrun_count_out
);

  localparam int         CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [3:0] GAP_LOAD = 4'(CDC_GAP_CYCLES - 1);

  cdc_sched_state_t state, state_next;
  logic [3:0]       gap_cnt;
  logic             req_pending;
  logic             arbitrate, tick_go, cfg_go;
  logic             flush, sample_write, fifo_pop;
  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count, count_next;
  stereo_sample_t   fifo_head, sample_in;

  assign sample_in    = {dsp1_in, dsp0_in};
  assign flush        = !play_in;
  assign sample_write = sample_valid_in && sample_ready_out && !fifo_full;
  assign fifo_pop     = tick_go && !fifo_empty;

  cdc_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .write (sample_write),
    .data  (sample_in),
    .pop   (fifo_pop),
    .flush (flush),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Ready is registered, so it must be derived from the occupancy after this edge.
  always_comb begin
    count_next = fifo_count;
    if (flush) begin
      count_next = '0;
    end else begin
      case ({sample_write, fifo_pop})
        2'b10:   count_next = fifo_count + CW'(1);
        2'b01:   count_next = fifo_count - CW'(1);
        default: count_next = fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gap_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == SEND_TICK || state == SEND_CFG) gap_cnt <= GAP_LOAD;
      else if (gap_cnt != '0)                      gap_cnt <= gap_cnt - 4'd1;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    arbitrate  = 1'b0;
    tick_go    = 1'b0;
    cfg_go     = 1'b0;
    case (state)
      IDLE:                arbitrate = 1'b1;
      SEND_TICK, SEND_CFG: state_next = GAP;
      GAP: begin
        if (gap_cnt == '0) begin
          arbitrate  = 1'b1;
          state_next = IDLE;
        end
      end
      default:             state_next = IDLE;
    endcase
    // Leaving GAP arbitrates directly, giving CDC_GAP_CYCLES+1 pulse spacing.
    if (arbitrate) begin
      if (play_in && (req_pending || cdc_req_in)) begin
        tick_go    = 1'b1;
        state_next = SEND_TICK;
      end else if (cfg_req_in) begin
        cfg_go     = 1'b1;
        state_next = SEND_CFG;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   req_pending <= 1'b0;
    else if (!play_in || tick_go) req_pending <= 1'b0;
    else if (cdc_req_in)          req_pending <= 1'b1;
  end

  // NOTE: state updates use non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_ready_out <= 1'b0;
      cfg_ack_out      <= 1'b0;
      cdc_dsp0_out     <= '0;
      cdc_dsp1_out     <= '0;
      cdc_tick_out     <= 1'b0;
      cdc_cfg_out      <= 1'b0;
      cdc_cfg_reg_out  <= '0;
      cdc_play_out     <= 1'b0;
      underrun_out     <= 1'b0;
    end else begin
      sample_ready_out <= play_in && (count_next != CW'(FIFO_DEPTH));
      cdc_play_out     <= play_in;
      cdc_tick_out     <= tick_go;
      cdc_cfg_out      <= cfg_go;
      cfg_ack_out      <= cfg_go;
      underrun_out     <= tick_go && fifo_empty;
      if (tick_go) {cdc_dsp1_out, cdc_dsp0_out} <= fifo_empty ? 48'd0 : fifo_head;
      if (cfg_go)  cdc_cfg_reg_out <= cfg_data_in;
    end
  end

`ifdef CDC_SCHED_UNDERRUN_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      underrun_count_out <= '0;
    else if (play_in && !cdc_play_out)
      underrun_count_out <= '0;
    else if (tick_go && fifo_empty && underrun_count_out != 16'hFFFF)
      underrun_count_out <= underrun_count_out + 16'd1;
  end
`else
  assign underrun_count_out = '0;
`endif

endmodule

// File: tb/tb_cdc_tx_scheduler.sv
// Directed bench for cdc_tx_scheduler with a queue of expected tick payloads.
module tb_cdc_tx_scheduler;

  logic        clk, rst_n;
  logic        sample_valid_in, sample_ready_out;
  logic [23:0] dsp0_in, dsp1_in;
  logic        cfg_req_in, cfg_ack_out;
  logic [31:0] cfg_data_in;
  logic        play_in, cdc_req_in;
  logic [23:0] cdc_dsp0_out, cdc_dsp1_out;
  logic        cdc_tick_out, cdc_cfg_out, cdc_play_out, underrun_out;
  logic [31:0] cdc_cfg_reg_out;
  logic [15:0] underrun_count_out;

  typedef struct {
    logic [23:0] d0;
    logic [23:0] d1;
    logic        ur;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   ticks;

  cdc_tx_scheduler dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .sample_valid_in    (sample_valid_in),
    .dsp0_in            (dsp0_in),
    .dsp1_in            (dsp1_in),
    .sample_ready_out   (sample_ready_out),
    .cfg_req_in         (cfg_req_in),
    .cfg_data_in        (cfg_data_in),
    .cfg_ack_out        (cfg_ack_out),
    .play_in            (play_in),
    .cdc_req_in         (cdc_req_in),
    .cdc_dsp0_out       (cdc_dsp0_out),
    .cdc_dsp1_out       (cdc_dsp1_out),
    .cdc_tick_out       (cdc_tick_out),
    .cdc_cfg_out        (cdc_cfg_out),
    .cdc_cfg_reg_out    (cdc_cfg_reg_out),
    .cdc_play_out       (cdc_play_out),
    .underrun_out       (underrun_out),
    .underrun_count_out (underrun_count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [23:0] d0, input logic [23:0] d1, input logic ur);
    exp_t e;
    e.d0 = d0;
    e.d1 = d1;
    e.ur = ur;
    sb.push_back(e);
  endtask

  // Compares the current tick pulse against the oldest expected payload.
  task automatic check_tick(input string tag);
    exp_t e;
    check({tag, "_tick"}, 64'(cdc_tick_out), 64'(1));
    if (sb.size() != 0) e = sb.pop_front();
    else begin
      e.d0 = '1;
      e.d1 = '1;
      e.ur = 1'b1;
    end
    check({tag, "_dsp0"}, 64'(cdc_dsp0_out), 64'(e.d0));
    check({tag, "_dsp1"}, 64'(cdc_dsp1_out), 64'(e.d1));
    check({tag, "_underrun"}, 64'(underrun_out), 64'(e.ur));
  endtask

  task automatic pulse_req();
    cdc_req_in = 1'b1;
    @(negedge clk);
    cdc_req_in = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; sample_valid_in = 1'b0; dsp0_in = '0; dsp1_in = '0;
    cfg_req_in = 1'b0; cfg_data_in = '0; play_in = 1'b0; cdc_req_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_tick", 64'(cdc_tick_out), 64'(0));
    check("rst_ready", 64'(sample_ready_out), 64'(0));
    check("rst_cfg_reg", 64'(cdc_cfg_reg_out), 64'(0));
    check("rst_count", 64'(underrun_count_out), 64'(0));
    rst_n = 1'b1;

    // Play on, two samples buffered, two requests ten cycles apart.
    play_in = 1'b1;
    @(negedge clk);
    check("play_ready", 64'(sample_ready_out), 64'(1));
    check("play_delay", 64'(cdc_play_out), 64'(1));
    sample_valid_in = 1'b1; dsp0_in = 24'h000111; dsp1_in = 24'h000222;
    push(24'h000111, 24'h000222, 1'b0);
    @(negedge clk);
    dsp0_in = 24'h000333; dsp1_in = 24'h000444;
    push(24'h000333, 24'h000444, 1'b0);
    @(negedge clk);
    sample_valid_in = 1'b0;
    pulse_req();
    check_tick("data1");
    @(negedge clk);
    check("gap_tick_low", 64'(cdc_tick_out), 64'(0));
    check("gap_dsp0_held", 64'(cdc_dsp0_out), 64'(24'h000111));
    repeat (8) @(negedge clk);
    pulse_req();
    check_tick("data2");
    repeat (8) @(negedge clk);

    // Empty FIFO underrun.
    push(24'h0, 24'h0, 1'b1);
    pulse_req();
    check_tick("underrun");
`ifdef CDC_SCHED_UNDERRUN_CNT_EN
    check("underrun_count", 64'(underrun_count_out), 64'(1));
`else
    check("underrun_count", 64'(underrun_count_out), 64'(0));
`endif
    @(negedge clk);
    check("underrun_pulse", 64'(underrun_out), 64'(0));
    repeat (8) @(negedge clk);

    // Simultaneous tick and cfg requests: tick first, cfg five cycles later.
    cfg_req_in = 1'b1; cfg_data_in = 32'hA5A5_0F0F;
    push(24'h0, 24'h0, 1'b1);
    pulse_req();
    check_tick("simul");
    check("simul_cfg_first", 64'(cdc_cfg_out), 64'(0));
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("simul_cfg_early", 64'(cdc_cfg_out), 64'(0));
    end
    @(negedge clk);
    check("simul_cfg", 64'(cdc_cfg_out), 64'(1));
    check("simul_ack", 64'(cfg_ack_out), 64'(1));
    check("simul_cfg_reg", 64'(cdc_cfg_reg_out), 64'(32'hA5A5_0F0F));
    cfg_req_in = 1'b0;
    @(negedge clk);
    check("ack_one_cycle", 64'(cfg_ack_out), 64'(0));
    check("cfg_reg_held", 64'(cdc_cfg_reg_out), 64'(32'hA5A5_0F0F));
    repeat (8) @(negedge clk);

    // Two requests during one GAP yield exactly one extra tick at GAP exit+1.
    push(24'h0, 24'h0, 1'b1);
    pulse_req();
    check_tick("b2b_first");
    push(24'h0, 24'h0, 1'b1);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      check("b2b_tick", 64'(cdc_tick_out), 64'(i == 5));
      if (cdc_tick_out) check_tick("b2b_extra");
      cdc_req_in = (i == 1 || i == 3);
    end
    cdc_req_in = 1'b0;
    check("b2b_sb_left", 64'(sb.size()), 64'(0));

    // Fill to full, ready must drop, then drain in order.
    for (int i = 0; i < 4; i++) begin
      check("fill_ready", 64'(sample_ready_out), 64'(1));
      sample_valid_in = 1'b1; dsp0_in = 24'h100 + 24'(i); dsp1_in = 24'h200 + 24'(i);
      push(24'h100 + 24'(i), 24'h200 + 24'(i), 1'b0);
      @(negedge clk);
    end
    sample_valid_in = 1'b0;
    check("full_ready", 64'(sample_ready_out), 64'(0));
    for (int j = 0; j < 3; j++) begin
      pulse_req();
      check_tick("drain");
      check("drain_ready", 64'(sample_ready_out), 64'(1));
      repeat (6) @(negedge clk);
    end
    pulse_req();
    check_tick("drain_last");

    // Reset for one cycle mid-GAP: outputs clear at once, FSM restarts in IDLE.
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_dsp0", 64'(cdc_dsp0_out), 64'(0));
    check("midrst_dsp1", 64'(cdc_dsp1_out), 64'(0));
    check("midrst_cfg_reg", 64'(cdc_cfg_reg_out), 64'(0));
    check("midrst_ready", 64'(sample_ready_out), 64'(0));
    check("midrst_play", 64'(cdc_play_out), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    push(24'h0, 24'h0, 1'b1);
    pulse_req();
    check_tick("post_rst");
    repeat (8) @(negedge clk);

    // Play low: requests ignored, ready stays low, no stale pending request.
    play_in = 1'b0;
    repeat (2) @(negedge clk);
    check("playlow_ready", 64'(sample_ready_out), 64'(0));
    ticks = 0;
    cdc_req_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cdc_req_in = 1'b0;
      if (cdc_tick_out) ticks++;
    end
    play_in = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (cdc_tick_out) ticks++;
    end
    check("playlow_ticks", 64'(ticks), 64'(0));
    check("replay_ready", 64'(sample_ready_out), 64'(1));

    // Three samples buffered, then play drops: FIFO flushed on the next edge.
    sample_valid_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dsp0_in = 24'h500 + 24'(i); dsp1_in = 24'h600 + 24'(i);
      @(negedge clk);
    end
    sample_valid_in = 1'b0;
    play_in = 1'b0;
    @(negedge clk);
    check("flush_empty", 64'(dut.u_fifo.empty), 64'(1));
    check("flush_ready", 64'(sample_ready_out), 64'(0));
    play_in = 1'b1;
    repeat (2) @(negedge clk);
    push(24'h0, 24'h0, 1'b1);
    pulse_req();
    check_tick("after_flush");
    repeat (8) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
